// File: rtl/snespad_emu.sv
// rtl/snespad_emu.sv - SNES pad serial responder driven by a local button source
//
// Purpose: lets the FPGA answer a SNES console/host as a pad. The host pulses
// dlatch, then clocks 16 bits out on dclk; each rising dclk edge advances to the
// next bit. The pins are asynchronous to clk, so each one is synchronised,
// glitch-filtered and edge-detected before the responder FSM sees it.
//
// Ports:
//   clk      in   1   system clock
//   rstn     in   1   asynchronous active-low reset
//   dlatch   in   1   latch pin from host, active high
//   dclk     in   1   serial clock pin from host, idles high
//   data     out  1   serial data to host, active low (0 = pressed)
//   buttons  in  12   1 = pressed; [0]B [1]Y [2]Sel [3]Start [4]Up [5]Down
//                     [6]Left [7]Right [8]A [9]X [10]L [11]R
//   poll     out  1   one-cycle pulse when an accepted latch falls
//   busy     out  1   high while latching or shifting
module snespad_emu #(
   parameter int SYSMHZ     = 100,
   parameter int FILT       = 4,
   parameter int TIMEOUT_US = 1000
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        dlatch,
   input  logic        dclk,
   output logic        data,
   input  logic [11:0] buttons,
   output logic        poll,
   output logic        busy
);

   localparam int TMO = SYSMHZ * TIMEOUT_US;
   localparam int TW  = $clog2(TMO + 1);
   localparam int CW  = (FILT > 1) ? $clog2(FILT) : 1;
   // Pin index 0 = latch, 1 = dclk; idle levels are latch low, dclk high.
   localparam logic [1:0] PIN_IDLE = 2'b10;

   typedef enum logic [1:0] {IDLE, LATCH, SHIFT, DONE} state_t;

   logic [1:0]          s1_q, s1_d, s2_q, s2_d;
   logic [1:0]          filt_q, filt_d, prev_q, prev_d;
   logic [1:0][CW-1:0]  cnt_q, cnt_d;

   state_t              state_q, state_d;
   logic [15:0]         sreg_q, sreg_d;
   logic [4:0]          nbit_q, nbit_d;
   logic [TW-1:0]       tmo_q, tmo_d;
   logic                data_q, data_d;
   logic                poll_q, poll_d;
   logic                busy_q, busy_d;

   logic                latch_f, latch_rise, latch_fall, dclk_rise;

   // Synchroniser and filter: a new level is accepted only after FILT
   // consecutive synchronised samples disagree with the current filtered level.
   always_comb begin
      s1_d   = {dclk, dlatch};
      s2_d   = s1_q;
      prev_d = filt_q;
      filt_d = filt_q;
      cnt_d  = cnt_q;
      for (int i = 0; i < 2; i++) begin
         if (s2_q[i] == filt_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CW'(FILT - 1)) begin
            filt_d[i] = s2_q[i];
            cnt_d[i]  = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s1_q   <= PIN_IDLE;
         s2_q   <= PIN_IDLE;
         filt_q <= PIN_IDLE;
         prev_q <= PIN_IDLE;
         cnt_q  <= '0;
      end else begin
         s1_q   <= s1_d;
         s2_q   <= s2_d;
         filt_q <= filt_d;
         prev_q <= prev_d;
         cnt_q  <= cnt_d;
      end
   end

   assign latch_f    = filt_q[0];
   assign latch_rise = filt_q[0] & ~prev_q[0];
   assign latch_fall = ~filt_q[0] & prev_q[0];
   assign dclk_rise  = filt_q[1] & ~prev_q[1];

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         sreg_q  <= 16'hFFFF;
         nbit_q  <= '0;
         tmo_q   <= '0;
         data_q  <= 1'b1;
         poll_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         nbit_q  <= nbit_d;
         tmo_q   <= tmo_d;
         data_q  <= data_d;
         poll_q  <= poll_d;
         busy_q  <= busy_d;
      end
   end

   // Next state: a latch rise restarts the transfer from any state.
   always_comb begin
      state_d = state_q;
      if (latch_rise) begin
         state_d = LATCH;
      end else begin
         case (state_q)
            LATCH: if (latch_fall) state_d = SHIFT;
            SHIFT: begin
               if (dclk_rise) begin
                  if (nbit_q == 5'd15) state_d = DONE;
               end else if (tmo_q == '0) begin
                  state_d = IDLE;
               end
            end
            default: ;
         endcase
      end
   end

   // Datapath and registered outputs
   always_comb begin
      sreg_d = sreg_q;
      nbit_d = nbit_q;
      tmo_d  = tmo_q;
      poll_d = 1'b0;
      // While the latch is held, keep tracking the buttons so the last
      // value before the fall is the one sent; dclk is ignored meanwhile.
      if (latch_rise || (state_q == LATCH && latch_f)) begin
         sreg_d = {4'hF, ~buttons};
         nbit_d = '0;
      end else begin
         case (state_q)
            LATCH: begin
               if (latch_fall) begin
                  poll_d = 1'b1;
                  nbit_d = '0;
                  tmo_d  = TW'(TMO);
               end
            end
            SHIFT: begin
               if (dclk_rise) begin
                  sreg_d = {1'b0, sreg_q[15:1]};
                  nbit_d = nbit_q + 5'd1;
                  tmo_d  = TW'(TMO);
               end else if (tmo_q != '0) begin
                  tmo_d = tmo_q - TW'(1);
               end
            end
            default: ;
         endcase
      end
      data_d = (state_d == IDLE) ? 1'b1 : sreg_d[0];
      busy_d = (state_d == LATCH) || (state_d == SHIFT);
   end

   assign data = data_q;
   assign poll = poll_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_snespad_emu.sv
// tb/tb_snespad_emu.sv - self-checking bench for snespad_emu
module tb_snespad_emu;

   localparam int SYSMHZ     = 4;
   localparam int FILT       = 4;
   localparam int TIMEOUT_US = 100;
   localparam int US         = SYSMHZ;
   localparam int TMO        = SYSMHZ * TIMEOUT_US;

   localparam int P_IDLE = 0;
   localparam int P_LAT  = 1;
   localparam int P_SEND = 2;
   localparam int P_FIN  = 3;

   logic        clk;
   logic        rstn;
   logic        dlatch;
   logic        dclk;
   logic        data;
   logic [11:0] buttons;
   logic        poll;
   logic        busy;

   int nvec = 0;
   int nmis = 0;
   int npoll = 0;
   bit chk_en = 0;

   logic [15:0] rd;
   int          rd_i;
   logic        hold_data;
   int          hold_poll;

   snespad_emu #(
      .SYSMHZ(SYSMHZ),
      .FILT(FILT),
      .TIMEOUT_US(TIMEOUT_US)
   ) dut (
      .clk(clk),
      .rstn(rstn),
      .dlatch(dlatch),
      .dclk(dclk),
      .data(data),
      .buttons(buttons),
      .poll(poll),
      .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   bit          lq[$];
   bit          cq[$];
   bit          m_lf, m_lfp, m_dc, m_dcp;
   bit          all_l, all_c, rise_l, fall_l, rise_c;
   int          m_ph, m_sent, m_gap, qn;
   logic [11:0] m_snap;
   logic [15:0] m_frame;
   logic        exp_data, exp_poll, exp_busy;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         lq.delete();
         cq.delete();
         for (int k = 0; k < FILT + 2; k++) begin
            lq.push_back(1'b0);
            cq.push_back(1'b1);
         end
         m_lf = 0; m_lfp = 0; m_dc = 1; m_dcp = 1;
         m_ph = P_IDLE; m_sent = 0; m_gap = 0; m_snap = '0;
         exp_data = 1'b1; exp_poll = 1'b0; exp_busy = 1'b0;
      end else begin
         // Transfer behaviour, seen through the filtered pin levels.
         rise_l = m_lf && !m_lfp;
         fall_l = !m_lf && m_lfp;
         rise_c = m_dc && !m_dcp;
         exp_poll = 1'b0;
         if (rise_l) begin
            m_ph = P_LAT;
            m_snap = buttons;
         end else if (m_ph == P_LAT) begin
            if (m_lf) begin
               m_snap = buttons;
            end else if (fall_l) begin
               m_ph = P_SEND; m_sent = 0; m_gap = 0; exp_poll = 1'b1;
            end
         end else if (m_ph == P_SEND) begin
            if (rise_c) begin
               m_sent++;
               m_gap = 0;
               if (m_sent == 16) m_ph = P_FIN;
            end else if (m_gap == TMO) begin
               m_ph = P_IDLE;
            end else begin
               m_gap++;
            end
         end
         m_frame = {4'hF, ~m_snap};
         if (m_ph == P_IDLE)     exp_data = 1'b1;
         else if (m_ph == P_LAT) exp_data = ~m_snap[0];
         else if (m_sent < 16)   exp_data = m_frame[m_sent];
         else                    exp_data = 1'b0;
         exp_busy = (m_ph == P_LAT) || (m_ph == P_SEND);

         // Pin filter: level flips once the last FILT synchronised samples
         // (pin values from 2..FILT+1 edges ago) all disagree with it.
         qn = lq.size();
         all_l = 1; all_c = 1;
         for (int k = 2; k <= FILT + 1; k++) begin
            if (lq[qn-k] == m_lf) all_l = 0;
            if (cq[qn-k] == m_dc) all_c = 0;
         end
         m_lfp = m_lf;
         m_dcp = m_dc;
         if (all_l) m_lf = !m_lf;
         if (all_c) m_dc = !m_dc;
         lq.push_back(dlatch);
         cq.push_back(dclk);
         void'(lq.pop_front());
         void'(cq.pop_front());
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("data", data, exp_data);
         chk("poll", poll, exp_poll);
         chk("busy", busy, exp_busy);
         if (poll === 1'b1) npoll++;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_latch(input logic [11:0] btn);
      buttons = btn;
      rd = '0;
      rd_i = 0;
      dlatch = 1'b1;
      wait_cyc(12 * US);
      dlatch = 1'b0;
      wait_cyc(6 * US);
   endtask

   task automatic pulse_clk();
      dclk = 1'b0;
      wait_cyc(6 * US);
      if (rd_i < 16) rd[rd_i] = data;
      rd_i++;
      dclk = 1'b1;
      wait_cyc(6 * US);
   endtask

   task automatic pulses(input int n);
      for (int i = 0; i < n; i++) pulse_clk();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      rstn = 1'b0;
      dlatch = 1'b0;
      dclk = 1'b1;
      buttons = '0;
      chk_en = 1'b1;
      wait_cyc(4);
      chk("reset_data", data, 1);
      chk("reset_busy", busy, 0);
      chk("reset_poll", poll, 0);
      rstn = 1'b1;
      wait_cyc(4);

      // Single B pressed: first bit read low, then 15 released bits.
      p0 = npoll;
      do_latch(12'h001);
      pulses(16);
      chk("b_only_bits", rd, 16'hFFFE);
      chk("b_only_done_data", data, 0);
      chk("b_only_done_busy", busy, 0);
      chk("b_only_polls", npoll - p0, 1);

      do_latch(12'hFFF);
      pulses(16);
      chk("all_pressed_bits", rd, 16'hF000);

      do_latch(12'h900);
      pulses(16);
      chk("a_r_bits", rd, 16'hF6FF);

      // Buttons change mid-transfer: only the next poll sees them.
      do_latch(12'h000);
      pulses(4);
      buttons = 12'hFFF;
      pulses(12);
      chk("midchange_bits", rd, 16'hFFFF);
      do_latch(12'hFFF);
      pulses(16);
      chk("after_change_bits", rd, 16'hF000);

      // Short glitches on dclk and dlatch are rejected.
      do_latch(12'h0A5);
      pulses(2);
      hold_data = data;
      hold_poll = npoll;
      dclk = 1'b0; wait_cyc(2); dclk = 1'b1; wait_cyc(20);
      chk("dclk_glitch_data", data, hold_data);
      dlatch = 1'b1; wait_cyc(2); dlatch = 1'b0; wait_cyc(20);
      chk("latch_glitch_data", data, hold_data);
      chk("latch_glitch_poll", npoll - hold_poll, 0);
      chk("latch_glitch_busy", busy, 1);
      pulses(14);
      chk("glitch_xfer_bits", rd, 16'hFF5A);

      // Latch re-asserted after 5 bits presents bit 0 again.
      do_latch(12'h001);
      pulses(5);
      chk("bit5_data", data, 1);
      dlatch = 1'b1;
      wait_cyc(12 * US);
      chk("relatch_data", data, 0);
      chk("relatch_busy", busy, 1);
      dlatch = 1'b0;
      wait_cyc(6 * US);
      rd = '0; rd_i = 0;
      pulses(16);
      chk("relatch_bits", rd, 16'hFFFE);

      // Host stops clocking after 3 bits for 1.1x the timeout.
      do_latch(12'h001);
      pulses(3);
      wait_cyc(TMO + TMO / 10);
      chk("timeout_busy", busy, 0);
      chk("timeout_data", data, 1);

      // Reset mid-shift, then a clean poll.
      do_latch(12'hFFF);
      pulses(3);
      chk("pre_reset_data", data, 0);
      #3 rstn = 1'b0;
      #1;
      chk("async_reset_data", data, 1);
      chk("async_reset_busy", busy, 0);
      chk("async_reset_poll", poll, 0);
      wait_cyc(3);
      rstn = 1'b1;
      wait_cyc(4);
      p0 = npoll;
      do_latch(12'h5A5);
      pulses(16);
      chk("post_reset_bits", rd, 16'hFA5A);
      chk("post_reset_polls", npoll - p0, 1);

      // Randomised traffic, checked every cycle against the model.
      for (int it = 0; it < 30; it++) begin
         int nb;
         buttons = 12'($urandom);
         dlatch = 1'b1;
         wait_cyc($urandom_range(1, 14));
         dlatch = 1'b0;
         wait_cyc($urandom_range(1, 10));
         nb = $urandom_range(0, 18);
         for (int b = 0; b < nb; b++) begin
            dclk = 1'b0;
            wait_cyc($urandom_range(1, 9));
            if ($urandom_range(0, 3) == 0) buttons = 12'($urandom);
            if ($urandom_range(0, 9) == 0) begin
               dlatch = 1'b1;
               wait_cyc($urandom_range(1, 6));
               dlatch = 1'b0;
            end
            dclk = 1'b1;
            wait_cyc($urandom_range(1, 9));
         end
         if ($urandom_range(0, 5) == 0) wait_cyc(TMO + 20);
      end
      wait_cyc(20);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
